mmio_uart_tx: RTL and testbench

Memory-mapped console transmitter that sits directly downstream of the pipelined CPU's store port (`data_write`, `data`, `data_address`). Byte stores to a fixed I/O address are captured into a small FIFO. The FIFO is drained by an 8N1 UART serializer, so program output leaves the chip on a single `tx` line without stalling the pipeline. Stores to any other address are ignored; this block never back-pressures the CPU.

---
 rtl/uart_pkg.sv | 16 +
 rtl/byte_fifo.sv | 67 ++++++
 rtl/mmio_uart_tx.sv | 141 ++++++++++++++
 tb/tb_mmio_uart_tx.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   uart_tx_state_t   : serializer FSM states
//   UART_TX_ADDR      : default store address that enqueues a byte
//   UART_CLKS_PER_BIT : default clocks per UART bit
//   UART_FIFO_DEPTH   : default FIFO depth
//   UART_CNT_W        : width of the bit-period counter (covers up to 65535 clocks/bit)
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  localparam logic [31:0] UART_TX_ADDR      = 32'h0000_FFF0;
  localparam int unsigned UART_CLKS_PER_BIT = 16;
  localparam int unsigned UART_FIFO_DEPTH   = 16;
  localparam int unsigned UART_CNT_W        = 16;

endpackage

// File: rtl/byte_fifo.sv
// Single-clock byte FIFO with synchronous active-low reset.
//   clk_i   : clock
//   rst_ni  : synchronous reset, active low (clears pointers and count)
//   push_i  : write data_i; ignored when full unless a pop happens in the same cycle
//   data_i  : byte to write
//   pop_i   : advance the read pointer; ignored when empty
//   head_o  : entry at the registered read pointer
//   full_o  : count == Depth
//   empty_o : count == 0
//   count_o : current occupancy
module byte_fifo #(
  parameter int unsigned Depth = 16,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [7:0]      data_i,
  input  logic            pop_i,
  output logic [7:0]      head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 console transmitter fed from the CPU store port.
// Byte stores to TX_ADDR are queued in a FIFO and serialized LSB first on tx.
// The CPU is never stalled; a store that finds the FIFO full is dropped and
// latches the sticky overflow flag.
//   clk          : clock
//   reset        : synchronous reset, active low
//   data_write   : store strobe
//   data         : store byte
//   data_address : store address
//   tx           : UART line, idle high
//   busy         : frame on the line or FIFO non-empty
//   overflow     : sticky dropped-store flag
//   fifo_count   : FIFO occupancy
module mmio_uart_tx import uart_pkg::*; #(
  parameter logic [31:0] TX_ADDR      = UART_TX_ADDR,
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = UART_FIFO_DEPTH,
  localparam int unsigned CntW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            data_write,
  input  logic [7:0]      data,
  input  logic [31:0]     data_address,
  output logic            tx,
  output logic            busy,
  output logic            overflow,
  output logic [CntW-1:0] fifo_count
);

  localparam int unsigned ClkCntW = UART_CNT_W;

  uart_tx_state_t     state_q, state_d;
  logic [ClkCntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               overflow_q, overflow_d;

  logic       push_req;
  logic       pop;
  logic       last_tick;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_head;

  assign push_req  = data_write & (data_address == TX_ADDR);
  assign last_tick = (clk_cnt_q == ClkCntW'(CLKS_PER_BIT - 1));
  // The next byte leaves the FIFO either from idle or on the final stop-bit
  // cycle, which gives back-to-back frames with no idle gap.
  assign pop = ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & last_tick));

  assign overflow_d = overflow_q | (push_req & fifo_full & ~pop);

  byte_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push_req),
    .data_i  (data),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx        = 1'b1;
    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (pop) begin
          shift_d = fifo_head;
          state_d = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (last_tick) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + ClkCntW'(1);
        end
      end
      DATA: begin
        tx = shift_q[0];
        if (last_tick) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + ClkCntW'(1);
        end
      end
      STOP: begin
        if (last_tick) begin
          clk_cnt_d = '0;
          if (pop) begin
            shift_d = fifo_head;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + ClkCntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE) | (fifo_count != '0);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// Inputs change and outputs are sampled on the falling clock edge. A line
// monitor decodes every complete 40-cycle frame into a queue.
module tb_mmio_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] ADDR  = 32'h0000_FFF0;

  logic        clk;
  logic        reset;
  logic        data_write;
  logic [7:0]  data;
  logic [31:0] data_address;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mmio_uart_tx #(
    .TX_ADDR      (ADDR),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_write   (data_write),
    .data         (data),
    .data_address (data_address),
    .tx           (tx),
    .busy         (busy),
    .overflow     (overflow),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: frame = 10 bits x CPB cycles.
  bit          mon_active = 1'b0;
  int          mon_off    = 0;
  int          mon_start  = 0;
  logic [39:0] samp;
  logic [7:0]  m_byte;
  bit          m_ok;
  logic [7:0]  rx_q[$];
  int          rx_start[$];
  bit          rx_ok[$];

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_off    = 0;
        samp[0]    = tx;
        mon_start  = cyc;
      end
    end else begin
      mon_off++;
      samp[mon_off] = tx;
      if (mon_off == 39) begin
        m_ok = (samp[0] === 1'b0) && (samp[36] === 1'b1);
        for (int k = 0; k < 10; k++)
          for (int j = 1; j < 4; j++)
            if (samp[4*k+j] !== samp[4*k]) m_ok = 1'b0;
        for (int i = 0; i < 8; i++) m_byte[i] = samp[4*(i+1)+2];
        rx_q.push_back(m_byte);
        rx_start.push_back(mon_start);
        rx_ok.push_back(m_ok);
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic set_bus(input logic we, input logic [31:0] a, input logic [7:0] d);
    data_write   = we;
    data_address = a;
    data         = d;
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_start.delete();
    rx_ok.delete();
  endtask

  task automatic wait_frames(input int n, input int limit);
    for (int i = 0; i < limit && rx_q.size() < n; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_bus(1'b0, 32'h0, 8'h00);
    repeat (3) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    total++; if (fifo_count !== 3'd0) begin
      bad++; $display("FAIL reset_count: got %0d want 0", fifo_count);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [9:0] frame;
    int         err;
    frame = {1'b1, 8'h55, 1'b0};
    err   = 0;
    clear_rx();
    set_bus(1'b1, ADDR, 8'h55);
    @(negedge clk);  // cycle N+1
    set_bus(1'b0, ADDR, 8'h00);
    total++; if (fifo_count !== 3'd1) begin
      bad++; $display("FAIL single_count_n1: got %0d want 1", fifo_count);
    end
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL single_tx_n1: got %b want 1", tx); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_n1: got %b want 1", busy); end
    @(negedge clk);  // cycle N+2, start bit begins
    total++; if (fifo_count !== 3'd0) begin
      bad++; $display("FAIL single_count_n2: got %0d want 0", fifo_count);
    end
    for (int o = 0; o < 40; o++) begin
      if (o > 0) @(negedge clk);
      if (tx !== frame[o/4]) err++;
    end
    total++; if (err != 0) begin
      bad++; $display("FAIL single_frame_shape: got %0d wrong cycles want 0", err);
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_stop: got %b want 1", busy); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL single_tx_end: got %b want 1", tx); end
    total++; if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
      bad++; $display("FAIL single_rx: got %0d frames want one 0x55", rx_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    logic [2:0] peak;
    exp  = '{8'h41, 8'h42, 8'h43};
    peak = '0;
    clear_rx();
    for (int i = 0; i < 3; i++) begin
      set_bus(1'b1, ADDR, exp[i]);
      @(negedge clk);
      if (fifo_count > peak) peak = fifo_count;
    end
    set_bus(1'b0, ADDR, 8'h00);
    for (int i = 0; i < 10; i++) begin
      if (fifo_count > peak) peak = fifo_count;
      @(negedge clk);
    end
    total++; if (peak !== 3'd2) begin bad++; $display("FAIL b2b_peak: got %0d want 2", peak); end
    wait_frames(3, 400);
    total++; if (rx_q.size() != 3) begin
      bad++; $display("FAIL b2b_frames: got %0d want 3", rx_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++; if (rx_q[i] !== exp[i] || !rx_ok[i]) begin
          bad++; $display("FAIL b2b_byte%0d: got %h ok=%0d want %h", i, rx_q[i], rx_ok[i], exp[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        total++; if (rx_start[i] - rx_start[i-1] != 40) begin
          bad++; $display("FAIL b2b_gap%0d: got %0d want 40", i, rx_start[i] - rx_start[i-1]);
        end
      end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_ignore();
    logic [31:0] addrs [5];
    logic        wes   [5];
    int          err;
    addrs = '{ADDR + 32'd4, ADDR + 32'd1, ADDR - 32'd1, 32'h0000_0000, ADDR};
    wes   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    err   = 0;
    clear_rx();
    for (int i = 0; i < 5; i++) begin
      set_bus(wes[i], addrs[i], 8'h99);
      @(negedge clk);
      if (tx !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0) err++;
    end
    set_bus(1'b0, ADDR, 8'h00);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0) err++;
    end
    total++; if (err != 0) begin bad++; $display("FAIL ignore_quiet: got %0d bad cycles want 0", err); end
    total++; if (rx_q.size() != 0) begin
      bad++; $display("FAIL ignore_frames: got %0d want 0", rx_q.size());
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp [5];
    exp = '{8'h10, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
    clear_rx();
    set_bus(1'b1, ADDR, 8'h10);
    @(negedge clk);
    set_bus(1'b0, ADDR, 8'h00);
    repeat (8) @(negedge clk);
    for (int i = 0; i < DEPTH + 2; i++) begin
      set_bus(1'b1, ADDR, 8'hA0 + 8'(i));
      @(negedge clk);
    end
    set_bus(1'b0, ADDR, 8'h00);
    total++; if (fifo_count !== 3'd4) begin
      bad++; $display("FAIL ovf_count: got %0d want 4", fifo_count);
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    wait_frames(5, 600);
    repeat (60) @(negedge clk);
    total++; if (rx_q.size() != 5) begin
      bad++; $display("FAIL ovf_frames: got %0d want 5", rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++; if (rx_q[i] !== exp[i] || !rx_ok[i]) begin
          bad++; $display("FAIL ovf_byte%0d: got %h ok=%0d want %h", i, rx_q[i], rx_ok[i], exp[i]);
        end
      end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovf_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int err;
    err = 0;
    clear_rx();
    set_bus(1'b1, ADDR, 8'h11);
    @(negedge clk);
    set_bus(1'b1, ADDR, 8'h22);
    @(negedge clk);
    set_bus(1'b1, ADDR, 8'h33);
    @(negedge clk);  // cycle N+3
    set_bus(1'b0, ADDR, 8'h00);
    repeat (16) @(negedge clk);  // cycle N+19: data bit 3 of the first frame
    total++; if (fifo_count !== 3'd2) begin
      bad++; $display("FAIL rstmid_count_pre: got %0d want 2", fifo_count);
    end
    reset = 1'b0;
    @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx: got %b want 1", tx); end
    total++; if (fifo_count !== 3'd0) begin
      bad++; $display("FAIL rstmid_count: got %0d want 0", fifo_count);
    end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rstmid_ovf: got %b want 0", overflow); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) err++;
    end
    total++; if (err != 0) begin bad++; $display("FAIL rstmid_quiet: got %0d bad cycles want 0", err); end
    total++; if (rx_q.size() != 0) begin
      bad++; $display("FAIL rstmid_frames: got %0d want 0", rx_q.size());
    end
  endtask

  task automatic test_stop_push();
    logic [7:0] exp [6];
    exp = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
    clear_rx();
    for (int i = 0; i < 5; i++) begin
      set_bus(1'b1, ADDR, exp[i]);
      @(negedge clk);
    end
    set_bus(1'b0, ADDR, 8'h00);  // cycle N+5
    repeat (35) @(negedge clk);   // cycle N+40
    total++; if (fifo_count !== 3'd4) begin
      bad++; $display("FAIL stoppush_full: got %0d want 4", fifo_count);
    end
    @(negedge clk);               // cycle N+41: last stop cycle
    set_bus(1'b1, ADDR, exp[5]);
    @(negedge clk);
    set_bus(1'b0, ADDR, 8'h00);
    total++; if (fifo_count !== 3'd4) begin
      bad++; $display("FAIL stoppush_count: got %0d want 4", fifo_count);
    end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL stoppush_ovf: got %b want 0", overflow); end
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL stoppush_next_start: got %b want 0", tx); end
    wait_frames(6, 800);
    total++; if (rx_q.size() != 6) begin
      bad++; $display("FAIL stoppush_frames: got %0d want 6", rx_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++; if (rx_q[i] !== exp[i] || !rx_ok[i]) begin
          bad++; $display("FAIL stoppush_byte%0d: got %h ok=%0d want %h", i, rx_q[i], rx_ok[i], exp[i]);
        end
      end
    end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL stoppush_ovf_end: got %b want 0", overflow); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stoppush_busy_end: got %b want 0", busy); end
  endtask

  initial begin
    reset = 1'b0;
    set_bus(1'b0, 32'h0, 8'h00);
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore();
    test_overflow();
    test_reset_mid();
    test_stop_push();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
